// File: rtl/mips_controller.sv
// mips_controller: multicycle control FSM for the 8-bit MIPS datapath
module mips_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       pcen,
  output logic [1:0] pcsource,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic [2:0] alucont
);
  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, FETCH4, DECODE, MEMADR, LBRD, LBWR,
    SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR, UNUSED
  } state_t;
  state_t state, next;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH1;
    else state <= next;
  always_comb begin
    next = FETCH1;
    case (state)
      FETCH1:  next = FETCH2;
      FETCH2:  next = FETCH3;
      FETCH3:  next = FETCH4;
      FETCH4:  next = DECODE;
      DECODE:  case (op)
                 6'b100000, 6'b101000: next = MEMADR;
                 6'b000000:            next = RTYPEEX;
                 6'b000100:            next = BEQEX;
                 6'b000010:            next = JEX;
                 6'b001000:            next = ADDIEX;
                 default:              next = FETCH1;
               endcase
      MEMADR:  next = (op == 6'b100000) ? LBRD : SBWR;
      LBRD:    next = LBWR;
      RTYPEEX: next = RTYPEWR;
      ADDIEX:  next = ADDIWR;
      default: next = FETCH1;
    endcase
  end
  always_comb begin
    memread  = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    irwrite  = 4'b0000;
    pcen     = 1'b0;
    pcsource = 2'b00;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alucont  = 3'b010;
    case (state)
      FETCH1, FETCH2: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        pcen    = 1'b1;
        irwrite = (state == FETCH1) ? 4'b0001 : 4'b0010;
      end
      FETCH3:  irwrite = 4'b0100;
      FETCH4:  irwrite = 4'b1000;
      DECODE:  alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      LBRD:    {memread, iord} = 2'b11;
      LBWR:    {regwrite, memtoreg} = 2'b11;
      SBWR:    {memwrite, iord} = 2'b11;
      RTYPEEX: begin
        alusrca = 1'b1;
        case (funct)
          6'b100000: alucont = 3'b010;
          6'b100010: alucont = 3'b110;
          6'b100100: alucont = 3'b000;
          6'b100101: alucont = 3'b001;
          6'b101010: alucont = 3'b111;
          default:   alucont = 3'b101;
        endcase
      end
      RTYPEWR: {regwrite, regdst} = 2'b11;
      BEQEX: begin
        alusrca  = 1'b1;
        alucont  = 3'b110;
        pcsource = 2'b01;
        pcen     = zero;
      end
      JEX: begin
        pcsource = 2'b10;
        pcen     = 1'b1;
      end
      ADDIWR:  regwrite = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mips_controller.sv
// tb_mips_controller: per-instruction output sequences checked against a spec-table model
module tb_mips_controller;
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic [3:0] irwrite;
    logic       pcen;
    logic [1:0] pcsource;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic [2:0] alucont;
  } ctl_t;
  logic clk = 1'b0, rst_n, zero;
  logic [5:0] op, funct;
  logic memread, memwrite, iord, pcen, alusrca, regwrite, regdst, memtoreg;
  logic [3:0] irwrite;
  logic [1:0] pcsource, alusrcb;
  logic [2:0] alucont;
  ctl_t act;
  ctl_t exp_q[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign act = {memread, memwrite, iord, irwrite, pcen, pcsource, alusrca, alusrcb,
                regwrite, regdst, memtoreg, alucont};
  mips_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcen(pcen), .pcsource(pcsource), .alusrca(alusrca), .alusrcb(alusrcb),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alucont(alucont)
  );
  function automatic ctl_t step(input string n, input logic [5:0] f, input logic z);
    ctl_t c = '0;
    c.alucont = 3'b010;
    if (n == "F1" || n == "F2") begin
      c.memread = 1; c.alusrcb = 2'b01; c.pcen = 1;
      c.irwrite = (n == "F1") ? 4'b0001 : 4'b0010;
    end
    else if (n == "F3") c.irwrite = 4'b0100;
    else if (n == "F4") c.irwrite = 4'b1000;
    else if (n == "DEC") c.alusrcb = 2'b11;
    else if (n == "ADR") begin c.alusrca = 1; c.alusrcb = 2'b10; end
    else if (n == "LBRD") begin c.memread = 1; c.iord = 1; end
    else if (n == "LBWR") begin c.regwrite = 1; c.memtoreg = 1; end
    else if (n == "SBWR") begin c.memwrite = 1; c.iord = 1; end
    else if (n == "REX") begin
      c.alusrca = 1;
      c.alucont = (f == 6'b100000) ? 3'b010 : (f == 6'b100010) ? 3'b110 :
                  (f == 6'b100100) ? 3'b000 : (f == 6'b100101) ? 3'b001 :
                  (f == 6'b101010) ? 3'b111 : 3'b101;
    end
    else if (n == "RWR") begin c.regwrite = 1; c.regdst = 1; end
    else if (n == "BEQ") begin c.alusrca = 1; c.alucont = 3'b110; c.pcsource = 2'b01; c.pcen = z; end
    else if (n == "JEX") begin c.pcsource = 2'b10; c.pcen = 1; end
    else if (n == "AWR") c.regwrite = 1;
    return c;
  endfunction
  task automatic model(input logic [5:0] o, input logic [5:0] f, input logic z);
    string names[$];
    names = '{"F1", "F2", "F3", "F4", "DEC"};
    case (o)
      6'b100000: names = {names, "ADR", "LBRD", "LBWR"};
      6'b101000: names = {names, "ADR", "SBWR"};
      6'b000000: names = {names, "REX", "RWR"};
      6'b000100: names = {names, "BEQ"};
      6'b000010: names = {names, "JEX"};
      6'b001000: names = {names, "ADR", "AWR"};
      default: ;
    endcase
    names.push_back("F1");
    exp_q.delete();
    foreach (names[i]) exp_q.push_back(step(names[i], f, z));
  endtask
  task automatic test_reset;
    rst_n = 0; op = 6'b000000; funct = 6'd0; zero = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (act !== step("F1", 0, 0)) begin bad++; $display("FAIL reset cyc%0d: got %h want %h", i, act, step("F1", 0, 0)); end
      if (i < 3) begin @(posedge clk); #1; end
    end
    rst_n = 1;
    @(posedge clk); #1;
    total++;
    if (act !== step("F2", 0, 0)) begin bad++; $display("FAIL reset release: got %h want %h", act, step("F2", 0, 0)); end
    rst_n = 0; #1;
    total++;
    if (act !== step("F1", 0, 0)) begin bad++; $display("FAIL async reset: got %h want %h", act, step("F1", 0, 0)); end
    rst_n = 1;
  endtask
  task automatic test_lb;
    op = 6'b100000; funct = 6'($urandom); zero = 1'($urandom);
    model(op, funct, zero);
    total++;
    if (exp_q.size() != 9) begin bad++; $display("FAIL lb length: got %0d want 9", exp_q.size()); end
    foreach (exp_q[i]) begin
      total++;
      if (act !== exp_q[i]) begin bad++; $display("FAIL lb step%0d: got %h want %h", i, act, exp_q[i]); end
      if (i < exp_q.size() - 1) begin @(posedge clk); #1; end
    end
  endtask
  task automatic test_rtype;
    logic [5:0] fl[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    foreach (fl[k]) begin
      op = 6'b000000; funct = fl[k]; zero = 1'($urandom);
      model(op, funct, zero);
      foreach (exp_q[i]) begin
        total++;
        if (act !== exp_q[i]) begin bad++; $display("FAIL rtype f=%b step%0d: got %h want %h", funct, i, act, exp_q[i]); end
        if (i < exp_q.size() - 1) begin @(posedge clk); #1; end
      end
    end
  endtask
  task automatic test_beq;
    for (int z = 1; z >= 0; z--) begin
      op = 6'b000100; funct = 6'($urandom); zero = 1'(z);
      model(op, funct, zero);
      foreach (exp_q[i]) begin
        total++;
        if (act !== exp_q[i]) begin bad++; $display("FAIL beq z=%0d step%0d: got %h want %h", z, i, act, exp_q[i]); end
        if (i < exp_q.size() - 1) begin @(posedge clk); #1; end
      end
    end
  endtask
  task automatic test_sb_reset;
    op = 6'b101000; funct = 6'($urandom); zero = 0;
    model(op, funct, zero);
    for (int i = 0; i <= 6; i++) begin
      total++;
      if (act !== exp_q[i]) begin bad++; $display("FAIL sb step%0d: got %h want %h", i, act, exp_q[i]); end
      if (i < 6) begin @(posedge clk); #1; end
    end
    rst_n = 0; #1;
    total++;
    if (memwrite !== 1'b0 || act !== step("F1", 0, 0)) begin
      bad++; $display("FAIL sb reset: got %h want %h", act, step("F1", 0, 0));
    end
    @(posedge clk); #1;
    rst_n = 1;
    total++;
    if (act !== step("F1", 0, 0)) begin bad++; $display("FAIL sb post-reset: got %h want %h", act, step("F1", 0, 0)); end
  endtask
  task automatic test_illegal;
    op = 6'b111111; funct = 6'($urandom); zero = 1;
    model(op, funct, zero);
    foreach (exp_q[i]) begin
      total++;
      if (act !== exp_q[i]) begin bad++; $display("FAIL illegal step%0d: got %h want %h", i, act, exp_q[i]); end
      if (i < exp_q.size() - 1) begin @(posedge clk); #1; end
    end
  endtask
  task automatic test_back_to_back;
    logic [5:0] ops[2] = '{6'b000010, 6'b001000};
    foreach (ops[k]) begin
      op = ops[k]; funct = 6'($urandom); zero = 1'($urandom);
      model(op, funct, zero);
      foreach (exp_q[i]) begin
        total++;
        if (act !== exp_q[i]) begin bad++; $display("FAIL b2b op=%b step%0d: got %h want %h", op, i, act, exp_q[i]); end
        if (i < exp_q.size() - 1) begin @(posedge clk); #1; end
      end
    end
  endtask
  task automatic test_random;
    logic [5:0] ol[7] = '{6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b000001};
    logic [5:0] fl[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ol[$urandom_range(0, 6)];
      funct = ($urandom_range(0, 1) == 1) ? 6'($urandom) : fl[$urandom_range(0, 5)];
      zero = 1'($urandom);
      model(op, funct, zero);
      foreach (exp_q[i]) begin
        if (op != 6'b000100) zero = 1'($urandom);
        #0;
        total++;
        if (act !== exp_q[i]) begin bad++; $display("FAIL random op=%b f=%b step%0d: got %h want %h", op, funct, i, act, exp_q[i]); end
        if (i < exp_q.size() - 1) begin @(posedge clk); #1; end
      end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_lb();
    test_rtype();
    test_beq();
    test_sb_reset();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
